// File: rtl/tpu_job_sequencer_if.sv
// Stream-in, stream-out and TPU bus bundle for the job sequencer.
// master = sequencer side (TPU bus master, input-stream sink, output-stream source).
interface tpu_job_sequencer_if #(
    parameter int DATAW = 64,
    parameter int ADDRW = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [DATAW-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [DATAW-1:0] out_data;
    logic             tpu_r_w;
    logic [ADDRW-1:0] tpu_addr;
    logic [DATAW-1:0] tpu_dataIn;
    logic [DATAW-1:0] tpu_dataOut;

    modport master (
        input  in_valid, in_data, out_ready, tpu_dataOut,
        output in_ready, out_valid, out_data, tpu_r_w, tpu_addr, tpu_dataIn
    );

    modport slave (
        output in_valid, in_data, out_ready, tpu_dataOut,
        input  in_ready, out_valid, out_data, tpu_r_w, tpu_addr, tpu_dataIn
    );
endinterface

// File: rtl/tpu_job_sequencer.sv
// Runs one TPU matmul job: load A/B/(C), issue MatMul, wait, stream C out; 58 cycles unstalled.
// Input stalls hold the load index; out_ready=0 holds the read address and data stable.
module tpu_job_sequencer #(
    parameter int DIM         = 8,
    parameter int DATAW       = 64,
    parameter int ADDRW       = 16,
    parameter int WAIT_CYCLES = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic                i_load_c,
    input  logic                i_abort,
    output logic                o_busy,
    output logic                o_done,
    tpu_job_sequencer_if.master bus
);
    localparam int WCW = $clog2(WAIT_CYCLES + 1);

    localparam logic [ADDRW-1:0] BASE_A = ADDRW'(16'h0100);
    localparam logic [ADDRW-1:0] BASE_B = ADDRW'(16'h0200);
    localparam logic [ADDRW-1:0] BASE_C = ADDRW'(16'h0300);
    localparam logic [ADDRW-1:0] CMD_MM = ADDRW'(16'h0400);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_LOAD_C, S_MATMUL, S_WAIT, S_READ_C, S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_idx;
    logic             r_load_c;
    logic [WCW-1:0]   r_wcnt;

    logic             w_loading;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_idx_last;
    logic             w_wait_last;
    logic [ADDRW-1:0] w_off;

    assign w_loading   = (r_state == S_LOAD_A) || (r_state == S_LOAD_B) || (r_state == S_LOAD_C);
    assign w_in_xfer   = w_loading && bus.in_valid && !i_abort;
    assign w_out_xfer  = (r_state == S_READ_C) && bus.out_ready && !i_abort;
    // C is two words per row, so its load and readback run twice as long as A/B.
    assign w_idx_last  = ((r_state == S_LOAD_C) || (r_state == S_READ_C)) ?
                         (r_idx == 4'(2*DIM - 1)) : (r_idx == 4'(DIM - 1));
    assign w_wait_last = (r_wcnt == WCW'(WAIT_CYCLES - 1));
    assign w_off       = ADDRW'({r_idx, 3'b000});

    assign bus.tpu_dataIn = bus.in_data;
    assign bus.out_data   = bus.tpu_dataOut;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_next = S_LOAD_A;
            S_LOAD_A: if (w_in_xfer && w_idx_last) w_next = S_LOAD_B;
            S_LOAD_B: if (w_in_xfer && w_idx_last) w_next = r_load_c ? S_LOAD_C : S_MATMUL;
            S_LOAD_C: if (w_in_xfer && w_idx_last) w_next = S_MATMUL;
            S_MATMUL: w_next = S_WAIT;
            S_WAIT:   if (w_wait_last) w_next = S_READ_C;
            S_READ_C: if (w_out_xfer && w_idx_last) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (i_abort) w_next = S_IDLE;
    end

    always_comb begin
        o_busy        = (r_state != S_IDLE);
        o_done        = (r_state == S_DONE) && !i_abort;
        bus.in_ready  = w_loading && !i_abort;
        bus.out_valid = (r_state == S_READ_C) && !i_abort;
        bus.tpu_r_w   = 1'b0;
        bus.tpu_addr  = '0;
        case (r_state)
            S_LOAD_A: if (w_in_xfer) begin bus.tpu_r_w = 1'b1; bus.tpu_addr = BASE_A + w_off; end
            S_LOAD_B: if (w_in_xfer) begin bus.tpu_r_w = 1'b1; bus.tpu_addr = BASE_B + w_off; end
            S_LOAD_C: if (w_in_xfer) begin bus.tpu_r_w = 1'b1; bus.tpu_addr = BASE_C + w_off; end
            S_MATMUL: if (!i_abort)  begin bus.tpu_r_w = 1'b1; bus.tpu_addr = CMD_MM; end
            S_READ_C: if (!i_abort)  bus.tpu_addr = BASE_C + w_off;
            default:  bus.tpu_addr = '0;
        endcase
    end

    // Index restarts on every state entry; the wait counter only runs inside WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_load_c <= 1'b0;
            r_wcnt   <= '0;
        end else begin
            if (w_next != r_state) begin
                r_idx <= '0;
            end else if (w_in_xfer || w_out_xfer) begin
                r_idx <= r_idx + 4'd1;
            end
            if ((r_state == S_IDLE) && i_start && !i_abort) begin
                r_load_c <= i_load_c;
            end
            if (r_state == S_WAIT) begin
                r_wcnt <= r_wcnt + WCW'(1);
            end else begin
                r_wcnt <= '0;
            end
        end
    end
endmodule
